// File: rtl/ifetch_unit.sv
// ifetch_unit: owns the PC, fetches from a combinational IMEM and queues {pc, instr} for decode
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [31:0]   imem_pc,
    input  logic [31:0]   imem_instr,
    output logic          fetch_valid,
    input  logic          fetch_ready,
    output logic [31:0]   fetch_pc,
    output logic [31:0]   fetch_instr,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [CW-1:0] queue_count
);
    localparam int AW = $clog2(DEPTH);
    logic [31:0]   pc;
    logic [63:0]   q [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          has, push, pop;
    logic          unused_lo;
    assign unused_lo = ^redirect_pc[1:0];
    always_comb begin
        has         = count != '0;
        fetch_valid = has & !redirect_valid;
        pop         = fetch_valid & fetch_ready;
        push        = !redirect_valid & ((count < CW'(DEPTH)) | pop);
    end
    assign imem_pc     = pc;
    assign queue_count = count;
    assign fetch_pc    = has ? q[rp][63:32] : '0;
    assign fetch_instr = has ? q[rp][31:0] : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[31:2], 2'b00};
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                pc <= pc + 32'd4;
                wp <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            if (push != pop) count <= push ? count + CW'(1) : count - CW'(1);
        end
    end
    // Payload storage needs no reset: outputs are gated by count
    always_ff @(posedge clk) begin
        if (push) q[wp] <= {imem_pc, imem_instr};
    end
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed checks of fetch sequencing, back-pressure, redirects and async reset
module tb_ifetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc, imem_instr, fetch_pc, fetch_instr, redirect_pc = '0;
    logic        fetch_valid, fetch_ready = 1'b1, redirect_valid = 1'b0;
    logic [1:0]  queue_count;
    int          n_cmp = 0, n_err = 0;

    ifetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h00: return 32'h0000_0000;
            32'h04: return 32'h0040_0093;
            32'h08: return 32'h0010_0113;
            32'h0C: return 32'h0020_81B3;
            32'h34: return 32'h0010_2023;
            32'h3C: return 32'h0040_0423;
            default: return 32'h5A00_0000 | a;
        endcase
    endfunction
    assign imem_instr = imem_word(imem_pc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_pc", imem_pc, 32'h0);
        chk("rst_valid", 32'(fetch_valid), 32'h0);
        chk("rst_count", 32'(queue_count), 32'h0);
        chk("rst_fpc", fetch_pc, 32'h0);
        chk("rst_finstr", fetch_instr, 32'h0);
        step;
        rst_n = 1'b1;
        chk("pre_valid", 32'(fetch_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step;
            chk("seq_pc", fetch_pc, 32'(4 * i));
            chk("seq_instr", fetch_instr, imem_word(32'(4 * i)));
            chk("seq_count", 32'(queue_count), 32'h1);
            chk("seq_valid", 32'(fetch_valid), 32'h1);
        end

        rst_n = 1'b0;
        fetch_ready = 1'b0;
        step;
        rst_n = 1'b1;
        step;
        step;
        chk("bp_count2", 32'(queue_count), 32'h2);
        chk("bp_imem2", imem_pc, 32'h8);
        repeat (3) step;
        chk("bp_count5", 32'(queue_count), 32'h2);
        chk("bp_imem5", imem_pc, 32'h8);
        chk("bp_head", fetch_pc, 32'h0);
        chk("bp_head_instr", fetch_instr, 32'h0);
        fetch_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step;
            chk("full_head", fetch_pc, 32'(4 * k));
            chk("full_instr", fetch_instr, imem_word(32'(4 * k)));
            chk("full_count", 32'(queue_count), 32'h2);
            chk("full_imem", imem_pc, 32'(8 + 4 * k));
        end

        redirect_valid = 1'b1;
        redirect_pc = 32'h34;
        #1;
        chk("rd_valid_low", 32'(fetch_valid), 32'h0);
        step;
        redirect_valid = 1'b0;
        chk("rd_count", 32'(queue_count), 32'h0);
        chk("rd_valid", 32'(fetch_valid), 32'h0);
        chk("rd_imem", imem_pc, 32'h34);
        step;
        chk("rd_fpc", fetch_pc, 32'h34);
        chk("rd_finstr", fetch_instr, 32'h0010_2023);
        chk("rd_valid2", 32'(fetch_valid), 32'h1);

        redirect_valid = 1'b1;
        redirect_pc = 32'h3E;
        #1;
        chk("mis_no_pop", 32'(fetch_valid), 32'h0);
        step;
        redirect_valid = 1'b0;
        chk("mis_imem", imem_pc, 32'h3C);
        chk("mis_count", 32'(queue_count), 32'h0);
        step;
        chk("mis_fpc", fetch_pc, 32'h3C);
        chk("mis_finstr", fetch_instr, 32'h0040_0423);

        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        step;
        chk("rr_imem1", imem_pc, 32'h10);
        redirect_pc = 32'h20;
        step;
        redirect_valid = 1'b0;
        chk("rr_count", 32'(queue_count), 32'h0);
        chk("rr_imem2", imem_pc, 32'h20);
        step;
        chk("rr_fpc", fetch_pc, 32'h20);

        fetch_ready = 1'b0;
        step;
        step;
        chk("mid_count", 32'(queue_count), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(fetch_valid), 32'h0);
        chk("ar_fpc", fetch_pc, 32'h0);
        chk("ar_finstr", fetch_instr, 32'h0);
        chk("ar_count", 32'(queue_count), 32'h0);
        chk("ar_imem", imem_pc, 32'h0);
        fetch_ready = 1'b1;
        step;
        rst_n = 1'b1;
        step;
        chk("ar_restart0", fetch_pc, 32'h0);
        step;
        chk("ar_restart4", fetch_pc, 32'h4);
        chk("ar_restart_instr", fetch_instr, 32'h0040_0093);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the fetch address into the combinational IMEM. It captures each returned word, together with its PC, into a small in-order queue. It hands entries to decode over a valid/ready handshake and accepts redirects from execute (branch/jump), which flush the queue and reload the PC.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, queue entries; power of two, ≥2.
- CW, $clog2(DEPTH+1), width of queue_count (derived, not overridden).

- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_pc  out  32  fetch address to IMEM; equals internal PC register.
- imem_instr  in  32  IMEM read data for imem_pc, valid in the same cycle.
- fetch_valid  out  1  head entry available to decode.
- fetch_ready  in  1  decode accepts head entry.
- fetch_pc  out  32  PC of head entry.
- fetch_instr  out  32  instruction word of head entry.
- redirect_valid  in  1  flush and reload PC this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored.
- queue_count  out  CW  number of occupied entries.

## Operation
- State: PC register, DEPTH×64-bit queue {pc, instr}, write pointer, read pointer, count.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count distinguishes full from empty.
- pop = fetch_valid & fetch_ready.
- push = !redirect_valid & (count < DEPTH | pop). A full queue accepts a push in the same cycle as a pop.
- On push: write {imem_pc, imem_instr} at the write pointer; PC <= PC + 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
- When push is not asserted and there is no redirect, PC holds and imem_pc is stable.
- Count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Redirect has priority over everything:
  - PC <= {redirect_pc[31:2], 2'b00}.
  - Count, read pointer and write pointer are cleared.
  - No push.
- fetch_valid = (count != 0) & !redirect_valid. It is forced low during a redirect cycle, so no handshake can complete on a word that is being flushed.
- fetch_pc and fetch_instr show the head entry when count != 0 and are driven 0 when the queue is empty.
- Decode-side signals have no influence on imem_pc in the same cycle except through push, because the PC advances only on push.

## Timing
- Reset (rst_n low, asynchronous):
  - PC = RESET_PC, imem_pc = RESET_PC.
  - count = 0 and pointers = 0.
  - fetch_valid = 0, fetch_pc = 0, fetch_instr = 0, queue_count = 0.
- First edge after release: pushes the word at RESET_PC. fetch_valid = 1 from that edge onward, so the first entry is visible 1 cycle after reset release.
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible at the head after edge N if the queue was empty.
- Throughput is 1 instruction/cycle with fetch_ready held high, at steady-state count 1.
- Redirect asserted in cycle N:
  - After edge N: count = 0, fetch_valid = 0, imem_pc = target.
  - After edge N+1: target word is at the head with fetch_valid = 1.
  - Total redirect penalty is 1 bubble cycle.
- Redirect while the queue is full or empty behaves identically.
- Redirect held on consecutive cycles keeps the queue empty. The last target wins.
- fetch_ready toggling while fetch_valid = 0 has no effect.
- Asynchronous reset mid-operation discards all queue contents immediately, without waiting for a clock edge.

## Test plan
- Reset release with fetch_ready=1, IMEM holding the standard test program:
  - fetch_pc is 0x0, 0x4, 0x8, 0xC on consecutive cycles.
  - fetch_instr is 0x00000000, 0x00400093, 0x00100113, 0x002081B3.
  - queue_count stays 1.
- Back-pressure with DEPTH=2, fetch_ready=0 for 5 cycles after reset:
  - queue_count reaches 2 and imem_pc stalls at 0x8.
  - Head stays at pc 0x0.
  - On release, pcs 0x0, 0x4, 0x8 are delivered in order with no drop or duplicate.
- Full queue with fetch_ready=1:
  - Push and pop occur in the same cycle.
  - queue_count holds 2 and imem_pc advances by 4 every cycle.
- Redirect to 0x00000034 while the queue holds 2 entries:
  - Next cycle: queue_count=0, fetch_valid=0, imem_pc=0x34.
  - Following cycle: fetch_pc=0x34, fetch_instr=0x00102023.
- Misaligned redirect to 0x0000003E, coincident with fetch_ready=1:
  - No pop completes in the redirect cycle.
  - imem_pc=0x3C, then fetch_instr=0x00400423.
- Reset mid-operation: rst_n driven low between clock edges with count=2.
  - fetch_valid, fetch_pc, fetch_instr and queue_count go to 0 immediately.
  - imem_pc=RESET_PC immediately.
  - After release, the sequence restarts at 0x0.
